// File: rtl/i2s_sum_deserializer_if.sv
// Parallel output side of the serial sum deserializer.
// The producer drives the head word; the consumer drives out_ready.
`timescale 1ns/1ps
interface i2s_sum_deserializer_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] out_data;
    logic             out_chan;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_chan,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_chan,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/i2s_sum_deserializer.sv
// Oversampling deserializer for the LSB-first two-channel sum stream.
// Rebuilds each word, tags it with its channel and queues it in a FIFO.
`timescale 1ns/1ps
module i2s_sum_deserializer #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sck,
    input  logic                       ws,
    input  logic                       sd,
    i2s_sum_deserializer_if.master     out,
    output logic                       overflow,
    output logic                       short_err,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_ARM,
        S_CAP,
        S_DONE
    } state_t;

    logic [2:0] sck_sync;
    logic [1:0] ws_sync;
    logic [1:0] sd_sync;
    logic       tick;
    logic       ws_s;
    logic       sd_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
        end else begin
            sck_sync <= {sck_sync[1:0], sck};
            ws_sync  <= {ws_sync[0], ws};
            sd_sync  <= {sd_sync[0], sd};
        end
    end

    assign tick = sck_sync[1] & ~sck_sync[2];
    assign ws_s = ws_sync[1];
    assign sd_s = sd_sync[1];

    state_t           state_q, state_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             chan_q, chan_d;
    logic             ws_prev_q, ws_prev_d;
    logic             push_q, push_d;
    logic [WIDTH:0]   push_word_q, push_word_d;
    logic             short_q, short_d;
    logic             boundary;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_ARM;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            chan_q      <= 1'b0;
            ws_prev_q   <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            chan_q      <= chan_d;
            ws_prev_q   <= ws_prev_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            short_q     <= short_d;
        end
    end

    assign boundary = ws_s ^ ws_prev_q;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        chan_d      = chan_q;
        ws_prev_d   = ws_prev_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        short_d     = 1'b0;
        if (tick) begin
            ws_prev_d = ws_s;
            if (boundary) begin
                // The boundary slot itself carries no data bit.
                if (state_q == S_CAP && bitcnt_q != '0)
                    short_d = 1'b1;
                bitcnt_d = '0;
                chan_d   = ws_s;
                state_d  = S_CAP;
            end else begin
                unique case (state_q)
                    S_CAP: begin
                        // LSB first: after WIDTH shifts bit 0 lands at [0].
                        shift_d  = {sd_s, shift_q[WIDTH-1:1]};
                        bitcnt_d = bitcnt_q + CW'(1);
                        if (bitcnt_q == LAST) begin
                            push_d      = 1'b1;
                            push_word_d = {chan_q, shift_d};
                            state_d     = S_DONE;
                        end
                    end
                    S_ARM, S_DONE: ;
                    default: state_d = S_ARM;
                endcase
            end
        end
    end

    assign short_err = short_q;

    logic [WIDTH:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           full;
    logic           empty;
    logic           pop;
    logic           wr_en;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = out.out_valid & out.out_ready;
    assign wr_en = push_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_word_q;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_q & full & ~pop)
                overflow <= 1'b1;
        end
    end

    assign out.out_valid = ~empty;
    assign out.out_data  = mem[rd_ptr[AW-1:0]][WIDTH-1:0];
    assign out.out_chan  = mem[rd_ptr[AW-1:0]][WIDTH];
    assign level         = wr_ptr - rd_ptr;
endmodule
